// File: rtl/srl_bank_if.sv
// Data/control bundle for srl_bank: shift/rotate controls and tap-read results.
interface srl_bank_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int FW    = $clog2(DEPTH + 1)
);
  logic             CE;
  logic             ROT;
  logic [WIDTH-1:0] D;
  logic [AW-1:0]    A;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Q_LAST;
  logic [FW-1:0]    FILL;
  logic             FULL;

  modport master (output CE, ROT, D, A, input Q, Q_LAST, FILL, FULL);
  modport slave  (input CE, ROT, D, A, output Q, Q_LAST, FILL, FULL);
endinterface

// File: rtl/srl_bank.sv
// Parameterised shift/rotate register bank with a combinational tap read
// and a saturating count of words shifted in since reset.
module srl_bank #(
  parameter int               WIDTH = 8,
  parameter int               DEPTH = 16,
  parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}},
  parameter int               AW    = $clog2(DEPTH)
) (
  input  logic      C,
  input  logic      R,
  srl_bank_if.slave bus
);
  localparam int FW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] stage [DEPTH];
  logic [FW-1:0]    fill;
  logic [WIDTH-1:0] q;

  // Reset beats enable; rotate feeds the last stage back instead of D.
  always_ff @(posedge C) begin
    if (R) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= INIT;
      fill <= '0;
    end else if (bus.CE) begin
      stage[0] <= bus.ROT ? stage[DEPTH-1] : bus.D;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      if (!bus.ROT && fill != FW'(DEPTH)) fill <= fill + 1'b1;
    end
  end

  // Out-of-range taps match no stage and fall through to zero.
  always_comb begin
    q = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.A == AW'(i)) q = stage[i];
    end
  end

  assign bus.Q      = q;
  assign bus.Q_LAST = stage[DEPTH-1];
  assign bus.FILL   = fill;
  assign bus.FULL   = (fill == FW'(DEPTH));
endmodule

// File: doc/srl_bank.md
SRL_BANK -- requirements
Module: srl_bank

Interface
REQ-001 Parameter WIDTH, default 8: data bits per stage, range 1..64.
REQ-002 Parameter DEPTH, default 16: number of stages, range 2..256; need not be a power of two.
REQ-003 Parameter INIT, default {WIDTH{1'b0}}: value loaded into every stage on reset.
REQ-004 Parameter AW, default clog2(DEPTH): tap address width.
REQ-005 C  input  1  clock; all state changes on the rising edge of C only.
REQ-006 R  input  1  reset; synchronous to C, active-high.
REQ-007 CE  input  1  clock enable; no state change except reset when low.
REQ-008 ROT  input  1  rotate mode; sampled only when CE=1.
REQ-009 D  input  WIDTH  serial data into stage 0.
REQ-010 A  input  AW  tap address selecting the stage driven onto Q.
REQ-011 Q  output  WIDTH  contents of stage[A]; combinational from A and stage state.
REQ-012 Q_LAST  output  WIDTH  contents of stage[DEPTH-1].
REQ-013 FILL  output  clog2(DEPTH+1)  count of valid shifted-in words, registered.
REQ-014 FULL  output  1  high when FILL==DEPTH; registered or decoded from registered FILL, no glitch path from inputs.

Function
REQ-015 Storage SHALL be DEPTH stages of WIDTH bits, stage[0] nearest D.
REQ-016 Priority on each rising C SHALL be R, then CE; R=1 overrides CE, ROT and D.
REQ-017 Shift: CE=1, ROT=0 -> stage[0]<=D, stage[i]<=stage[i-1] for i=1..DEPTH-1, all in the same edge.
REQ-018 Rotate: CE=1, ROT=1 -> stage[0]<=stage[DEPTH-1], stage[i]<=stage[i-1]; D ignored.
REQ-019 Hold: CE=0 -> all stages, FILL unchanged regardless of ROT, D.
REQ-020 FILL SHALL increment by 1 on each shift edge, saturating at DEPTH; no wrap to 0.
REQ-021 FILL SHALL be unchanged on rotate edges and hold cycles.
REQ-022 Q SHALL update combinationally when A changes (zero-cycle read latency); write-to-Q latency is one C edge.
REQ-023 A>=DEPTH (possible for non-power-of-two DEPTH) SHALL drive Q to all zeros, never X.
REQ-024 Shift when FULL=1 SHALL discard the old stage[DEPTH-1] word; FILL stays DEPTH, FULL stays 1.
REQ-025 Rotate with FILL<DEPTH SHALL move INIT-valued stages as data; FILL does not change.
REQ-026 No internal X propagation: with D, A and CE known, Q, Q_LAST, FILL and FULL are known after the first reset.

Reset
REQ-027 R=1 at a rising C SHALL set every stage to INIT, FILL to 0 and FULL to 0 on that edge.
REQ-028 Reset SHALL take effect mid-sequence (any FILL, any ROT/CE) with no partial shift on that edge.
REQ-029 Before the first reset edge, stage contents are undefined; nothing is guaranteed until reset.
REQ-030 After R deasserts, the first CE=1 edge SHALL perform a normal shift or rotate.

Verification (WIDTH=8, DEPTH=4, INIT=8'hA5)
REQ-031 Reset: R=1 for one edge -> Q_LAST=8'hA5, Q=8'hA5 for A=0..3, FILL=0, FULL=0.
REQ-032 Shift fill: after reset, CE=1, ROT=0, D=01,02,03,04 on 4 edges -> stage[0..3]=04,03,02,01, FILL=4, FULL=1; a 5th shift with D=05 -> Q_LAST=02, FILL=4.
REQ-033 Rotate: from stage[0..3]=04,03,02,01, one CE=1, ROT=1 edge with D=FF -> stage[0..3]=01,04,03,02, FILL=4; 4 rotate edges restore the original order.
REQ-034 Hold/priority: CE=0, D toggling over 10 edges -> no change; then R=1 with CE=1, ROT=1 on the same edge -> all stages A5, FILL=0.
REQ-035 Partial fill and rotate: reset, shift D=11 twice, then rotate once -> stage[0..3]=A5,11,11,A5, FILL=2, FULL=0.
REQ-036 Address edge (DEPTH=3, AW=2): A=3 -> Q=8'h00; sweeping A=0..2 without a C edge -> Q follows stage[A] in the same cycle.
